mem_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester and the data (load/store) requester of the 5-stage pipeline.
- Sequences each access through issue and wait phases.
- Returns a one-cycle ack with read data to the requester that owns the access.
- Drives the pipeline-wide stall while any request is outstanding.
- Data accesses have priority; a streak counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 52 +++++
 rtl/arb_priority.sv | 37 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// Imported by the arbiter top and its priority sub-block.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [31:0] POISON_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  function automatic mem_cmd_t fetch_cmd(
    input logic [31:0] addr
  );
    mem_cmd_t c;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = '0;
    c.be    = 4'hF;
    return c;
  endfunction

  // Loads always read the full word; only stores use byte enables.
  function automatic mem_cmd_t data_cmd(
    input logic        we,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  be
  );
    mem_cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = we ? wdata : '0;
    c.be    = we ? be : 4'hF;
    return c;
  endfunction

endpackage

// File: rtl/arb_priority.sv
// Grant decision for the memory port: data first, with a
// streak counter that forces a fetch grant after MAX_STREAK.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant_strobe,
  output owner_t owner
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak;
  logic          fetch_turn;

  assign fetch_turn = i_req & (~d_req | (streak == SMAX));
  assign owner      = fetch_turn ? OWN_I : OWN_D;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (grant_strobe) begin
      if (owner == OWN_D && i_req) begin
        streak <= (streak == SMAX) ? streak : streak + 1'b1;
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters,
// sequencing each access through ISSUE/WAIT with a timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          MAX_STREAK = 4,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] POISON     = POISON_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        stall,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  arb_state_t    state;
  owner_t        own;
  owner_t        pick;
  logic [TW-1:0] timer;
  logic          grant;
  logic          expired;
  logic          got_rsp;
  logic          fin;
  logic          fin_err;
  logic [31:0]   fin_val;
  mem_cmd_t      nxt_cmd;

  assign grant   = (state == IDLE) & (i_req | d_req);
  assign expired = (timer == TLAST);
  assign got_rsp = (state == WAIT) & m_rvalid;

  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  arb_priority #(
    .MAX_STREAK(MAX_STREAK)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .d_req       (d_req),
    .grant_strobe(grant),
    .owner       (pick)
  );

  always_comb begin
    nxt_cmd = (pick == OWN_I)
            ? fetch_cmd(i_addr)
            : data_cmd(d_we, d_addr, d_wdata, d_be);
  end

  // An accepted ISSUE beats a same-cycle timeout.
  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_val = POISON;
    if (got_rsp) begin
      fin     = 1'b1;
      fin_err = m_err;
      if (!m_err) begin
        fin_val = m_we ? '0 : m_rdata;
      end
    end else if (expired) begin
      if ((state == ISSUE && !m_ready) || state == WAIT) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      own     <= OWN_I;
      timer   <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            own     <= pick;
            m_we    <= nxt_cmd.we;
            m_addr  <= nxt_cmd.addr;
            m_wdata <= nxt_cmd.wdata;
            m_be    <= nxt_cmd.be;
            m_req   <= 1'b1;
            timer   <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= timer + 1'b1;
          if (m_ready) begin
            m_req <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        m_req <= 1'b0;
        state <= DONE;
        if (fin_err) begin
          err <= 1'b1;
        end
        if (own == OWN_I) begin
          i_ack   <= 1'b1;
          i_rdata <= fin_val;
        end else begin
          d_ack   <= 1'b1;
          d_rdata <= fin_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single
// accesses plus streak, timeout, bus-error and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        stall;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_STREAK(4),
    .TIMEOUT   (64),
    .POISON    (32'hDEAD_BEEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_be    (d_be),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_ready (m_ready),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .stall   (stall),
    .err     (err)
  );

  // Memory model: m_ready after rdy_dly ISSUE cycles, then
  // m_rvalid after rv_dly more cycles unless hang is set.
  int          rdy_dly = 0;
  int          rv_dly = 0;
  bit          hang = 1'b0;
  bit          merr = 1'b0;
  logic [31:0] mrd = '0;
  bit          mbusy = 1'b0;
  int          mcnt = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      mbusy    = 1'b0;
      mcnt     = 0;
    end else begin
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      if (i_ack || d_ack) begin
        mbusy = 1'b0;
        mcnt  = 0;
      end else if (m_req && !mbusy) begin
        if (mcnt == rdy_dly) begin
          m_ready = 1'b1;
          mbusy   = 1'b1;
          mcnt    = 0;
        end else begin
          mcnt++;
        end
      end else if (mbusy && !hang) begin
        if (mcnt == rv_dly) begin
          m_rvalid = 1'b1;
          m_err    = merr;
          m_rdata  = mrd;
          mbusy    = 1'b0;
          mcnt     = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  int          r_lat;
  logic [31:0] r_rd;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  bit          r_got;
  bit          r_seen;
  bit          r_stable;
  bit          r_stall_ok;
  bit          r_wrong;

  task automatic access(input string name, input bit f, input bit we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] rd,
                        input int rdy, input int rv, input bit me,
                        input bit hg, input int budget);
    rdy_dly = rdy;
    rv_dly  = rv;
    mrd     = rd;
    merr    = me;
    hang    = hg;
    r_got = 0; r_seen = 0; r_lat = 0; r_rd = '0;
    r_stable = 1; r_stall_ok = 1; r_wrong = 0;
    if (f) begin
      i_req  = 1'b1;
      i_addr = a;
    end else begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_be    = be;
    end
    for (int c = 1; c <= budget && !r_got; c++) begin
      @(posedge clk); #1;
      if (m_req) begin
        if (!r_seen) begin
          r_seen  = 1;
          r_we    = m_we;
          r_addr  = m_addr;
          r_wdata = m_wdata;
          r_be    = m_be;
        end else if ({m_we, m_addr, m_wdata, m_be} !=
                     {r_we, r_addr, r_wdata, r_be}) begin
          r_stable = 0;
        end
      end
      if (f ? d_ack : i_ack) r_wrong = 1;
      if (f ? i_ack : d_ack) begin
        r_got = 1;
        r_lat = c;
        r_rd  = f ? i_rdata : d_rdata;
        if (stall) r_stall_ok = 0;
      end else if (!stall) begin
        r_stall_ok = 0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk({name, "_ack"}, 32'(r_got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic verify(input string name, input int lat,
                        input logic [31:0] rd);
    chk({name, "_lat"}, r_lat, lat);
    chk({name, "_rdata"}, r_rd, rd);
    chk({name, "_stall"}, 32'(r_stall_ok), 32'd1);
    chk({name, "_owner"}, 32'(r_wrong), 32'd0);
  endtask

  typedef struct {
    string       name;
    bit          f;
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] mrd;
    int          rdy;
    int          rv;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    int          exp_lat;
  } vec_t;

  vec_t  tbl[5];
  string exp_ord = "DDDDIDDDDI";
  byte   got_ord[10];
  int    n;

  initial begin
    tbl[0] = '{"fetch", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0,
               32'h2008_0001, 0, 0, 32'h2008_0001, 4'hF, 3};
    tbl[1] = '{"store", 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678,
               4'b0011, 32'hAAAA_AAAA, 3, 0, 32'h0, 4'b0011, 6};
    tbl[2] = '{"load", 1'b0, 1'b0, 32'h0000_3004, 32'hFFFF_FFFF,
               4'h1, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D, 4'hF, 6};
    tbl[3] = '{"fetch_slow", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0,
               32'h0000_0013, 2, 4, 32'h0000_0013, 4'hF, 9};
    tbl[4] = '{"store_full", 1'b0, 1'b1, 32'h0000_2FFC, 32'h8000_0001,
               4'hF, 32'h5555_5555, 0, 1, 32'h0, 4'hF, 4};

    @(posedge clk); #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      access(tbl[k].name, tbl[k].f, tbl[k].we, tbl[k].a, tbl[k].wd,
             tbl[k].be, tbl[k].mrd, tbl[k].rdy, tbl[k].rv, 1'b0,
             1'b0, 40);
      verify(tbl[k].name, tbl[k].exp_lat, tbl[k].exp_rd);
      chk({tbl[k].name, "_m_addr"}, r_addr, tbl[k].a);
      chk({tbl[k].name, "_m_we"}, 32'(r_we), 32'(tbl[k].we));
      chk({tbl[k].name, "_m_be"}, 32'(r_be), 32'(tbl[k].exp_be));
      chk({tbl[k].name, "_hold"}, 32'(r_stable), 32'd1);
      if (tbl[k].we) chk({tbl[k].name, "_m_wdata"}, r_wdata, tbl[k].wd);
    end

    // Both requesters held: four data grants, then one fetch.
    rdy_dly = 0; rv_dly = 0; merr = 0; hang = 0;
    i_addr = 32'h0000_1100;
    d_addr = 32'h0000_2200;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(posedge clk); #1;
      if (i_ack && d_ack) chk("streak_dual_ack", 32'd1, 32'd0);
      if (i_ack) begin got_ord[n] = "I"; n++; end
      else if (d_ack) begin got_ord[n] = "D"; n++; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("streak_count", n, 10);
    for (int k = 0; k < n; k++)
      chk($sformatf("streak_%0d", k), 32'(got_ord[k]), 32'(exp_ord[k]));
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("pre_timeout_err", 32'(err), 32'd0);
    access("timeout", 1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0,
           32'h1111_1111, 0, 0, 1'b0, 1'b1, 100);
    verify("timeout", 65, 32'hDEAD_BEEF);
    chk("timeout_err", 32'(err), 32'd1);
    access("after_to", 1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'h0,
           32'h0102_0304, 0, 0, 1'b0, 1'b0, 40);
    verify("after_to", 3, 32'h0102_0304);
    chk("after_to_err", 32'(err), 32'd1);

    access("ld_err", 1'b0, 1'b0, 32'h0000_3008, 32'h0, 4'h0,
           32'h0BAD_0BAD, 0, 0, 1'b1, 1'b0, 40);
    verify("ld_err", 3, 32'hDEAD_BEEF);
    chk("ld_err_err", 32'(err), 32'd1);
    access("after_err", 1'b1, 1'b0, 32'h0000_100C, 32'h0, 4'h0,
           32'h0050_0093, 0, 0, 1'b0, 1'b0, 40);
    verify("after_err", 3, 32'h0050_0093);

    // Reset while the access sits in WAIT.
    rdy_dly = 0; rv_dly = 6; merr = 0; hang = 0;
    mrd     = 32'h9999_9999;
    d_we    = 1'b0;
    d_addr  = 32'h0000_300C;
    d_req   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_wait", 32'(m_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_m_req", 32'(m_req), 32'd0);
    chk("mid_rst_d_ack", 32'(d_ack), 32'd0);
    chk("mid_rst_i_ack", 32'(i_ack), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_stall_req", 32'(stall), 32'd1);
    d_req = 1'b0;
    #1;
    chk("mid_rst_stall_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_m_req", 32'(m_req), 32'd0);
    chk("post_rst_ack", 32'(d_ack | i_ack), 32'd0);
    access("post_rst", 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0,
           32'h7777_0000, 0, 0, 1'b0, 1'b0, 40);
    verify("post_rst", 3, 32'h7777_0000);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
